// File: rtl/xcvr_test_system_rx_packer.sv
// Packs 64-bit receive words into 128-bit entries and queues them in a show-ahead
// FIFO, with sticky overflow and a saturating count of discarded 64-bit words.
module xcvr_test_system_rx_packer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  output logic [127:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  input  logic             clear_stats
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    held_q, held_d;
  logic           push_req;
  logic           sop_drop;
  logic [127:0]   push_data;

  logic [127:0]   mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic           full, empty, pop, wr_en, ovf_drop;
  logic [127:0]   head_d;

  logic [CNT_W-1:0] cnt_base, cnt_d;
  logic [CNT_W:0]   cnt_sum;
  logic [1:0]       cnt_inc;

  // Packer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Packer next-state: pair words, realign on sop while a half is held
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    push_req  = 1'b0;
    sop_drop  = 1'b0;
    push_data = {in_data, held_q};
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          held_d  = in_data;
          state_d = HALF;
        end
      end
      HALF: begin
        if (in_valid) begin
          if (in_sop) begin
            sop_drop = 1'b1;
            held_d   = in_data;
          end else begin
            push_req = 1'b1;
            state_d  = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // FIFO control; a pop frees a slot for a push in the same cycle even when full
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop      = out_valid & out_ready;
    wr_en    = push_req & (~full | pop);
    ovf_drop = push_req & full & ~pop;
    rd_ptr_d = rd_ptr + PW'(pop);
    wr_ptr_d = wr_ptr + PW'(wr_en);
    // Head for next cycle: bypass the incoming word when it lands in the head slot
    if (wr_en && (wr_ptr[AW-1:0] == rd_ptr_d[AW-1:0]))
      head_d = push_data;
    else
      head_d = mem[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      out_valid <= (wr_ptr_d != rd_ptr_d);
      out_data  <= head_d;
    end
  end

  // Drop statistics: clear first, then add this cycle's drop, saturating
  always_comb begin
    cnt_base = clear_stats ? '0 : drop_count;
    if (sop_drop)      cnt_inc = 2'd1;
    else if (ovf_drop) cnt_inc = 2'd2;
    else               cnt_inc = 2'd0;
    cnt_sum = {1'b0, cnt_base} + (CNT_W+1)'(cnt_inc);
    cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      drop_count <= cnt_d;
      overflow   <= (overflow & ~clear_stats) | ovf_drop;
    end
  end

endmodule

// File: tb/tb_xcvr_test_system_rx_packer.sv
// Bench for xcvr_test_system_rx_packer: directed scenarios plus random traffic
// against a queue-based reference model; a narrow-counter instance covers saturation.
module tb_xcvr_test_system_rx_packer;

  localparam int DEPTH = 4;
  localparam int SMAX  = 7;
  localparam int BMAX  = 65535;

  logic         clk;
  logic         reset;
  logic [63:0]  in_data;
  logic         in_valid, in_sop, out_ready, clear_stats;
  logic [127:0] out_data, s_out_data;
  logic         out_valid, overflow, s_out_valid, s_overflow;
  logic [15:0]  drop_count;
  logic [2:0]   s_drop_count;

  xcvr_test_system_rx_packer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .drop_count(drop_count), .clear_stats(clear_stats));

  xcvr_test_system_rx_packer #(.DEPTH(DEPTH), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .overflow(s_overflow), .drop_count(s_drop_count), .clear_stats(clear_stats));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model state
  bit           m_half;
  logic [63:0]  m_held;
  logic [127:0] m_q[$];
  int           m_cnt, m_scnt;
  bit           m_ovf;

  logic [63:0]  w [10];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    bit pop, push, full, ovf_ev;
    logic [127:0] pd;
    int inc;
    pop = (m_q.size() != 0) && out_ready;
    full = (m_q.size() == DEPTH);
    push = 0; ovf_ev = 0; inc = 0; pd = '0;
    if (in_valid) begin
      if (!m_half) begin
        m_held = in_data; m_half = 1;
      end else if (in_sop) begin
        m_held = in_data; inc = 1;
      end else begin
        pd = {in_data, m_held}; push = 1; m_half = 0;
      end
    end
    if (pop) m_q.delete(0);
    if (push) begin
      if (!full || pop) m_q.push_back(pd);
      else begin inc = 2; ovf_ev = 1; end
    end
    if (clear_stats) begin m_cnt = 0; m_scnt = 0; m_ovf = 0; end
    m_cnt  = sat(m_cnt + inc, BMAX);
    m_scnt = sat(m_scnt + inc, SMAX);
    if (ovf_ev) m_ovf = 1;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_q.size() != 0);
    check("s_out_valid", s_out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("out_data", out_data, m_q[0]);
      check("s_out_data", s_out_data, m_q[0]);
    end
    check("overflow", overflow, m_ovf);
    check("s_overflow", s_overflow, m_ovf);
    check("drop_count", drop_count, 128'(m_cnt));
    check("s_drop_count", s_drop_count, 128'(m_scnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic word(input logic [63:0] d, input logic sop);
    in_valid = 1'b1; in_data = d; in_sop = sop;
    step();
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_pulse();
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 128'h0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_cnt"}, drop_count, 128'h0);
  endtask

  task automatic model_reset();
    m_q.delete(); m_half = 0; m_held = '0; m_cnt = 0; m_scnt = 0; m_ovf = 0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 0; in_sop = 0; out_ready = 0; clear_stats = 0;
    model_reset();
    #1;
    reset_outputs_zero("rst0");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Basic pairing and first-entry latency
    out_ready = 1'b1;
    word(64'h1111, 1'b0);
    check("t1_early_valid", out_valid, 1'b0);
    word(64'h2222, 1'b0);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, {64'h2222, 64'h1111});
    idle(1);

    // Realign: A, B(sop), C
    word(64'hAAAA_0000_0000_000A, 1'b0);
    word(64'hBBBB_0000_0000_000B, 1'b1);
    word(64'hCCCC_0000_0000_000C, 1'b0);
    check("t2_data", out_data, {64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B});
    check("t2_cnt", drop_count, 128'd1);
    idle(1);

    // Overflow: 10 words with no reads
    out_ready = 1'b0;
    clear_pulse();
    for (int i = 0; i < 10; i++) begin
      w[i] = {$urandom, $urandom};
      word(w[i], 1'b0);
    end
    check("t3_ovf", overflow, 1'b1);
    check("t3_cnt", drop_count, 128'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain", out_data, {w[2*i+1], w[2*i]});
      step();
    end
    check("t3_empty", out_valid, 1'b0);

    // Simultaneous push and pop while full
    out_ready = 1'b0;
    clear_pulse();
    for (int i = 0; i < 9; i++) begin
      w[i] = {$urandom, $urandom};
      word(w[i], 1'b0);
    end
    w[9] = {$urandom, $urandom};
    out_ready = 1'b1;
    word(w[9], 1'b0);
    out_ready = 1'b0;
    idle(1);
    check("t4_cnt", drop_count, 128'd0);
    check("t4_ovf", overflow, 1'b0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("t4_drain", out_data, {w[2*i+1], w[2*i]});
      step();
    end
    check("t4_empty", out_valid, 1'b0);

    // Saturation on the 3-bit counter, then clear
    clear_pulse();
    word(64'h5, 1'b0);
    for (int i = 0; i < 8; i++) word(64'(i), 1'b1);
    check("t5_sat", s_drop_count, 128'd7);
    check("t5_wide", drop_count, 128'd8);
    clear_stats = 1'b1;
    word(64'h99, 1'b1);
    clear_stats = 1'b0;
    check("t5_clr_drop", s_drop_count, 128'd1);
    clear_pulse();
    check("t5_clr", s_drop_count, 128'd0);
    check("t5_clr_ovf", overflow, 1'b0);
    word(64'h77, 1'b0);
    idle(1);

    // Reset mid-stream with two entries held and a half pending
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) word({$urandom, $urandom}, 1'b0);
    check("t6_pre", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    reset_outputs_zero("t6_rst");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    word(64'h3333, 1'b0);
    word(64'h4444, 1'b0);
    check("t6_data", out_data, {64'h4444, 64'h3333});
    check("t6_cnt", drop_count, 128'd0);
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom % 4) != 0;
      in_sop      = ($urandom % 8) == 0;
      in_data     = {$urandom, $urandom};
      out_ready   = ($urandom % 3) != 0;
      clear_stats = ($urandom % 32) == 0;
      step();
    end
    in_valid = 0; in_sop = 0; clear_stats = 0; out_ready = 1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/xcvr_test_system_rx_packer.md
XCVR_TEST_SYSTEM_RX_PACKER -- requirements
Module: xcvr_test_system_rx_packer

Interface
REQ-001 Parameter DEPTH, default 4, sets output buffer depth in 128-bit entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 16, sets the drop counter width.
REQ-003 Port clk, input, 1 bit, is the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-005 Port in_data, input, 64 bits, is the receive word from the transceiver.
REQ-006 Port in_valid, input, 1 bit, SHALL qualify in_data; there is no backpressure toward the input.
REQ-007 Port in_sop, input, 1 bit, marks the word that SHALL start a new 128-bit word (realign); it is valid only with in_valid.
REQ-008 Port out_data, output, 128 bits, is the packed word at the buffer head.
REQ-009 Port out_valid, output, 1 bit, SHALL be high while the buffer is non-empty.
REQ-010 Port out_ready, input, 1 bit: out_valid and out_ready both high in a cycle SHALL pop one entry.
REQ-011 Port overflow, output, 1 bit, is a sticky drop flag.
REQ-012 Port drop_count, output, CNT_W bits, is a saturating count of discarded 64-bit words.
REQ-013 Port clear_stats, input, 1 bit, is a synchronous clear for overflow and drop_count.

Function
REQ-014 The packer SHALL have two states: EMPTY (no half held) and HALF (low half held).
REQ-015 In EMPTY, a word with in_valid SHALL be stored as low half [63:0] and the state SHALL go to HALF.
REQ-016 In HALF, a word with in_valid and in_sop low SHALL form {in_data, held} with in_data in [127:64]; this SHALL be pushed to the buffer and the state SHALL return to EMPTY.
REQ-017 In HALF, a word with in_valid and in_sop high SHALL discard the held half and increment drop_count by 1; in_data SHALL become the new low half and the state SHALL stay HALF.
REQ-018 In EMPTY, in_sop SHALL have no extra effect.
REQ-019 The buffer SHALL be a show-ahead FIFO: out_data SHALL equal the oldest entry whenever out_valid is high.
REQ-020 Latency: out_valid SHALL rise on the clock edge after the second word's in_valid cycle when the buffer was empty.
REQ-021 If the buffer is full and no pop occurs, a push SHALL be dropped; overflow SHALL be set and drop_count SHALL increase by 2.
REQ-022 If the buffer is full and a pop occurs in the same cycle as a push, the push SHALL be accepted and no drop recorded.
REQ-023 A pop and a push in the same cycle on a non-full buffer SHALL leave the occupancy unchanged.
REQ-024 drop_count SHALL saturate at all-ones and never wrap.
REQ-025 clear_stats SHALL zero overflow and drop_count; a drop event in the same cycle SHALL be applied after the clear (result: count equals that event's increment, overflow per REQ-021).
REQ-026 out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-027 FIFO read and write pointers SHALL be DEPTH-modulo with one extra wrap bit used for full/empty.

Reset
REQ-028 On reset assertion, asynchronously: state SHALL be EMPTY, the buffer SHALL be empty, out_valid=0, overflow=0, drop_count=0, and out_data=0.
REQ-029 A held half-word in progress at reset SHALL be lost and not counted.
REQ-030 On the first edge after deassertion, inputs SHALL be processed normally.

Verification
REQ-031 The bench SHALL drive in_data 0x1111 then 0x2222 with out_ready=1 -> next cycle out_valid=1 and out_data={0x2222,0x1111}.
REQ-032 The bench SHALL drive words A, B(sop), C -> out_data={C,B} and drop_count=1.
REQ-033 With out_ready=0 and DEPTH=4, the bench SHALL drive 10 words -> 4 entries held, overflow=1, drop_count=2; draining SHALL yield the first 4 pairs in order.
REQ-034 With the buffer full, the bench SHALL push and pop in the same cycle -> no drop, occupancy stays 4, and order is preserved.
REQ-035 The bench SHALL force drop_count to all-ones, cause a drop, then pulse clear_stats -> the count stays all-ones, then 0, and overflow=0.
REQ-036 The bench SHALL assert reset mid-stream with HALF and 2 entries held -> all outputs zero immediately, and the next pair is packed cleanly.
